// File: rtl/peripheral_regs.sv
// Shared register map for the VIA-style timer peripheral.
// Holds the register offsets and the bit positions used in ACR, IFR and IER,
// so that the RTL and any software model agree on a single definition.
package peripheral_regs;

  // Register offsets presented on address[2:0].
  typedef enum logic [2:0] {
    RegT1cl = 3'd0,
    RegT1ch = 3'd1,
    RegT1ll = 3'd2,
    RegT1lh = 3'd3,
    RegAcr  = 3'd4,
    RegIfr  = 3'd5,
    RegIer  = 3'd6,
    RegRsvd = 3'd7
  } via_reg_t;

  // ACR: timer 1 free-run select.
  localparam int unsigned ACR_FREE_RUN = 6;
  // IFR: timer 1 flag and the "any enabled interrupt pending" summary bit.
  localparam int unsigned IFR_T1  = 0;
  localparam int unsigned IFR_IRQ = 7;
  // IER: timer 1 enable and the set/clear control bit on writes.
  localparam int unsigned IER_T1  = 0;
  localparam int unsigned IER_SET = 7;

endpackage

// File: rtl/down_counter16.sv
// 16-bit down counter with synchronous parallel load.
// Ports:
//   clk_in     - clock, state advances on the rising edge
//   reset      - asynchronous active-high reset, count returns to 16'hFFFF
//   load       - load load_value on this edge instead of decrementing
//   load_value - value taken when load is high
//   count      - current count
//   underflow  - high while count is zero, i.e. the next edge is an underflow edge
module down_counter16 (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count,
  output logic        underflow
);

  logic [15:0] count_d, count_q;

  // Decrementing from zero wraps to 16'hFFFF, which is the one-shot behaviour.
  always_comb begin
    count_d = count_q - 16'd1;
    if (load) begin
      count_d = load_value;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_q <= 16'hFFFF;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign underflow = (count_q == 16'h0000);

endmodule

// File: rtl/via_timer.sv
// VIA-style timer 1: register decode, latch, interrupt flag and enable.
// Ports:
//   clk_in     - system clock (shared with the CPU)
//   reset      - asynchronous active-high reset
//   cs         - chip select from the address decoder
//   READ_write - bus direction, 0 = read, 1 = write
//   address    - register offset
//   data_in    - write data from the CPU
//   data_out   - read data to the CPU, 8'h00 when not being read
//   nmib       - active-low interrupt request
module via_timer
  import peripheral_regs::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       cs,
  input  logic       READ_write,
  input  logic [2:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       nmib
);

  via_reg_t reg_sel;
  logic     wr, rd, wr_t1ch, flag_clr;

  logic [15:0] latch_d, latch_q;
  logic        free_run_d, free_run_q;
  logic        ier_en_d, ier_en_q;
  logic        flag_d, flag_q;
  logic        armed_d, armed_q;

  logic        cnt_load;
  logic [15:0] cnt_load_value;
  logic [15:0] count;
  logic        underflow;

  assign reg_sel = via_reg_t'(address);
  assign wr      = cs & READ_write;
  assign rd      = cs & ~READ_write;
  assign wr_t1ch = wr && (reg_sel == RegT1ch);

  // A T1CH write loads the new value even on an underflow edge.
  assign cnt_load       = wr_t1ch | (underflow & free_run_q);
  assign cnt_load_value = wr_t1ch ? {data_in, latch_q[7:0]} : latch_q;

  down_counter16 u_counter (
    .clk_in     (clk_in),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .count      (count),
    .underflow  (underflow)
  );

  assign flag_clr = (rd && (reg_sel == RegT1cl)) ||
                    (wr && (reg_sel == RegT1lh)) ||
                    (wr && (reg_sel == RegIfr) && data_in[IFR_T1]);

  always_comb begin
    latch_d    = latch_q;
    free_run_d = free_run_q;
    ier_en_d   = ier_en_q;
    flag_d     = flag_q;
    armed_d    = armed_q;

    if (wr) begin
      case (reg_sel)
        RegT1cl, RegT1ll: latch_d[7:0]  = data_in;
        RegT1ch, RegT1lh: latch_d[15:8] = data_in;
        RegAcr:           free_run_d    = data_in[ACR_FREE_RUN];
        RegIer: begin
          if (data_in[IER_T1]) begin
            ier_en_d = data_in[IER_SET];
          end
        end
        default: ;
      endcase
    end

    if (flag_clr) begin
      flag_d = 1'b0;
    end
    // Underflow set takes priority over a clear on the same edge; only an
    // armed timer reports, so nothing fires after reset until T1CH is written.
    if (underflow && armed_q) begin
      flag_d = 1'b1;
      if (!free_run_q) begin
        armed_d = 1'b0;
      end
    end
    if (wr_t1ch) begin
      flag_d  = 1'b0;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      latch_q    <= 16'hFFFF;
      free_run_q <= 1'b0;
      ier_en_q   <= 1'b0;
      flag_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      latch_q    <= latch_d;
      free_run_q <= free_run_d;
      ier_en_q   <= ier_en_d;
      flag_q     <= flag_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (!reset && rd) begin
      case (reg_sel)
        RegT1cl: data_out = count[7:0];
        RegT1ch: data_out = count[15:8];
        RegT1ll: data_out = latch_q[7:0];
        RegT1lh: data_out = latch_q[15:8];
        RegAcr:  data_out[ACR_FREE_RUN] = free_run_q;
        RegIfr: begin
          data_out[IFR_T1]  = flag_q;
          data_out[IFR_IRQ] = flag_q & ier_en_q;
        end
        RegIer: begin
          data_out[IER_SET] = 1'b1;
          data_out[IER_T1]  = ier_en_q;
        end
        default: ;
      endcase
    end
  end

  assign nmib = ~(flag_q & ier_en_q);

endmodule

// File: doc/via_timer.md
VIA_TIMER -- requirements
Module: via_timer

Interface
REQ-001 SHALL use one clock and one reset: reset is asynchronous and active-high; all other state changes on the rising edge of clk_in.
REQ-002 SHALL have ports:
- clk_in  input  1  system clock (same as the CPU).
- reset  input  1  asynchronous, active-high.
- cs  input  1  chip select from the address decoder.
- READ_write  input  1  CPU bus direction: 0 = read, 1 = write.
- address  input  3  register offset, address_out[2:0].
- data_in  input  8  CPU data_out.
- data_out  output  8  read data to CPU data_in.
- nmib  output  1  active-low interrupt request to the CPU nmib.

Function
REQ-003 SHALL decode the register map below (cs=1); offset 7 reads 8'h00 and ignores writes:
- 0 T1CL: read = counter[7:0]; write = latch[7:0].
- 1 T1CH: read = counter[15:8]; write = latch[15:8].
- 2 T1LL: read/write latch[7:0].
- 3 T1LH: read/write latch[15:8].
- 4 ACR: bit6 = free-run; other bits read 0.
- 5 IFR: bit0 = T1 flag; bit7 = T1 flag AND IER enable.
- 6 IER.
REQ-004 SHALL drive data_out combinationally from address when cs=1 and READ_write=0, and 8'h00 otherwise.
REQ-005 SHALL apply all write and read side effects only at the clock edge where cs=1.
REQ-006 SHALL, on a write to T1CH, update latch[15:8], load the 16-bit counter with {data_in, latch[7:0]} on that edge, clear the T1 flag, and arm the timer.
REQ-007 SHALL, on a write to T1LH, update latch[15:8] and clear the T1 flag, without touching the counter or the armed state.
REQ-008 SHALL clear the T1 flag on a read of T1CL (READ_write=0).
REQ-009 SHALL clear the T1 flag on a write to IFR with data_in[0]=1; data_in[0]=0 SHALL leave it unchanged.
REQ-010 SHALL handle IER writes as follows: data_in[7]=1 sets the enable for each data_in[0]=1 bit; data_in[7]=0 clears it. IER reads return {1'b1, 6'b0, enable}.
REQ-011 SHALL decrement the counter by 1 on every clock edge, whether armed or not, except on an edge that loads it.
REQ-012 SHALL treat the edge where counter==16'h0000 as an underflow:
- One-shot mode (ACR[6]=0): counter wraps to 16'hFFFF; if armed, set the T1 flag and disarm.
- Free-run mode (ACR[6]=1): counter reloads from latch; set the T1 flag; stay armed.
REQ-013 SHALL, after a T1CH write with latch N, set the flag on the edge N+1 cycles after the write edge. Latch 0 gives 1 cycle.
REQ-014 SHALL let the set win over the clear when an underflow set and a flag clear (REQ-008/009) land on the same edge.
REQ-015 SHALL let the T1CH load win over the underflow when a T1CH write and an underflow land on the same edge: counter loads, flag is cleared, timer is armed.
REQ-016 SHALL drive nmib = ~(T1 flag & enable) from registers, glitch-free, with no additional latency.
REQ-017 SHALL ignore accesses while cs=0, including a pending read side effect.

Reset
REQ-018 SHALL, while reset is asserted, force:
- counter = 16'hFFFF; latch = 16'hFFFF.
- ACR = 0, IER enable = 0, T1 flag = 0, armed = 0.
- nmib = 1; data_out = 8'h00.
REQ-019 SHALL abandon any in-progress count when reset asserts mid-operation, and SHALL produce no flag after reset deasserts until T1CH is written.

Structure
REQ-020 SHALL take the register offsets (enum via_reg_t), the ACR_FREE_RUN bit index and the IFR/IER bit indices from shared package peripheral_regs.
REQ-021 SHALL hold the 16-bit load/decrement/underflow logic in one sub-module, down_counter16, with ports load, load_value, and underflow output; register decode and flags stay in via_timer.

Verification
REQ-022 Bench SHALL cover these scenarios:
- One-shot: write T1CL=8'h05, T1CH=8'h00 -> flag set exactly 6 edges after the T1CH edge; nmib stays 1 (IER=0); counter reads 16'hFFFF on the next cycle; no second flag after a further 70000 cycles.
- Enable: IER write 8'h81, then one-shot 8'h0003 -> nmib low 4 edges after T1CH; read T1CL -> nmib high the next edge; IFR read = 8'h81 before the clear and 8'h00 after.
- Free-run: ACR=8'h40, latch 8'h0002 -> flag every 3 cycles; clearing via IFR write 8'h01 each time re-asserts 3 cycles later.
- Simultaneous events: IFR clear on the underflow edge -> flag stays 1; T1CH write on the underflow edge -> flag 0, counter = new value.
- Reset mid-count: assert reset at counter 16'h0010 -> all values per REQ-018 immediately (asynchronous); no flag for 100 cycles after release.
- Read mux: cs=0 or READ_write=1 -> data_out=8'h00; offset 7 reads 8'h00; T1LL/T1LH read back the written 8'hA5/8'h5A.
